// File: rtl/store_monitor.sv
// Purpose: passive watcher on the processor data write port; flags the end-of-program store, a cycle timeout, and keeps a circular log of recent stores.
// Latency: done/timeout/result/counters update on the accepting edge; log read port is registered, one cycle after log_idx.
// Backpressure: none; observe-only, every store is accepted in RUN and ignored in DONE/TIMEOUT. Optional csum output under STORE_MON_CHECKSUM_EN.
module store_monitor #(
    parameter int AW             = 8,
    parameter int DW             = 8,
    parameter int DEPTH          = 8,
    parameter int END_ADDR       = 255,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CW             = 16,
    parameter int TW             = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AW-1:0]              rw_addr,
    input  logic [DW-1:0]              w,
    input  logic                       w_en,
    input  logic [$clog2(DEPTH)-1:0]   log_idx,
    output logic [AW-1:0]              log_addr,
    output logic [DW-1:0]              log_data,
    output logic                       log_vld,
    output logic                       done,
    output logic                       timeout,
    output logic [DW-1:0]              result,
    output logic [CW-1:0]              store_cnt,
    output logic [TW-1:0]              cycle_cnt
`ifdef STORE_MON_CHECKSUM_EN
    ,
    output logic [DW-1:0]              csum
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [AW-1:0] END_A   = AW'(END_ADDR);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_DONE, ST_TIMEOUT} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    state_t        state_q, state_d;
    entry_t        log_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   ent_cnt;
    logic [PW-1:0] rd_pos;
    logic          rd_hit;
    logic          running;
    logic          store_acc;
    logic          term_hit;
    logic          to_hit;

    assign running   = (state_q == ST_RUN);
    assign store_acc = running && w_en;
    assign term_hit  = store_acc && (rw_addr == END_A);
    // A terminating store on the timeout edge takes priority over the timeout.
    assign to_hit    = running && (cycle_cnt == TO_LAST) && !term_hit;

    assign done    = (state_q == ST_DONE);
    assign timeout = (state_q == ST_TIMEOUT);

    // Newest entry sits just behind the write pointer; wraps naturally in PW bits.
    assign rd_pos = wr_ptr - PW'(1) - log_idx;
    assign rd_hit = ({1'b0, log_idx} < ent_cnt);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Next-state: DONE and TIMEOUT are absorbing until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (term_hit)    state_d = ST_DONE;
                else if (to_hit) state_d = ST_TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    // Run counters, result capture and log bookkeeping; all frozen outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            store_cnt <= '0;
            result    <= '0;
            wr_ptr    <= '0;
            ent_cnt   <= '0;
        end else if (running) begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (w_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (ent_cnt != DEPTH_C) ent_cnt   <= ent_cnt + 1'b1;
                if (store_cnt != '1)    store_cnt <= store_cnt + 1'b1;
                if (term_hit)           result    <= w;
            end
        end
    end

    // Log RAM write; contents are never cleared, validity comes from ent_cnt.
    always_ff @(posedge clk) begin
        if (store_acc && !rst) log_mem[wr_ptr] <= '{addr: rw_addr, data: w};
    end

    // Registered read port; reads pre-write contents (no bypass), works in every state.
    always_ff @(posedge clk) begin
        if (rst || !rd_hit) begin
            log_addr <= '0;
            log_data <= '0;
            log_vld  <= 1'b0;
        end else begin
            log_addr <= log_mem[rd_pos].addr;
            log_data <= log_mem[rd_pos].data;
            log_vld  <= 1'b1;
        end
    end

`ifdef STORE_MON_CHECKSUM_EN
    // Rotate-left-by-one then XOR each accepted store's data.
    always_ff @(posedge clk) begin
        if (rst)            csum <= '0;
        else if (store_acc) csum <= {csum[DW-2:0], csum[DW-1]} ^ w;
    end
`endif

endmodule

// File: tb/tb_store_monitor.sv
// Purpose: randomized plus directed scoreboard bench for store_monitor against a queue-based reference.
// Latency: expectations are pushed at stimulus time and popped one clock edge later.
// Backpressure: none; the monitor consumes one expectation per clock.
module tb_store_monitor;

    localparam int AW = 8, DW = 8, DEPTH = 8, END_ADDR = 255;
    localparam int TIMEOUT_CYCLES = 1000, CW = 16, TW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] rw_addr = '0;
    logic [DW-1:0] w = '0;
    logic          w_en = 1'b0;
    logic [2:0]    log_idx = '0;
    logic [AW-1:0] log_addr;
    logic [DW-1:0] log_data;
    logic          log_vld;
    logic          done;
    logic          timeout;
    logic [DW-1:0] result;
    logic [CW-1:0] store_cnt;
    logic [TW-1:0] cycle_cnt;
`ifdef STORE_MON_CHECKSUM_EN
    logic [DW-1:0] csum;
`endif

    store_monitor #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .END_ADDR(END_ADDR),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CW(CW), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst), .rw_addr(rw_addr), .w(w), .w_en(w_en),
        .log_idx(log_idx), .log_addr(log_addr), .log_data(log_data),
        .log_vld(log_vld), .done(done), .timeout(timeout), .result(result),
        .store_cnt(store_cnt), .cycle_cnt(cycle_cnt)
`ifdef STORE_MON_CHECKSUM_EN
        , .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;

    typedef struct packed {
        logic        done;
        logic        to;
        logic [7:0]  result;
        logic [15:0] sc;
        logic [15:0] cc;
        logic [7:0]  la;
        logic [7:0]  ld;
        logic        lv;
        logic [7:0]  cs;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: history of stores (newest first) and plain run counters.
    ent_t hist[$];
    bit   m_done, m_to;
    int   m_res, m_sc, m_cc, m_cs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, req);
        end
    endtask

    task automatic step(input bit r, input bit en, input int a, input int d, input int k);
        exp_t e;
        ent_t n;
        @(negedge clk);
        rst = r; w_en = en; rw_addr = 8'(a); w = 8'(d); log_idx = 3'(k);
        e = '0;
        // Read port sees the log as it was before this edge.
        if (!r && k < hist.size()) begin
            e.la = hist[k].a;
            e.ld = hist[k].d;
            e.lv = 1'b1;
        end
        if (r) begin
            hist.delete();
            m_done = 0; m_to = 0; m_res = 0; m_sc = 0; m_cc = 0; m_cs = 0;
        end else if (!m_done && !m_to) begin
            m_cc++;
            if (en) begin
                n.a = 8'(a); n.d = 8'(d);
                hist.push_front(n);
                if (hist.size() > DEPTH) void'(hist.pop_back());
                if (m_sc < 65535) m_sc++;
                m_cs = (((m_cs << 1) | (m_cs >> 7)) & 8'hff) ^ d;
                if (a == END_ADDR) begin
                    m_done = 1;
                    m_res  = d;
                end
            end
            if (!m_done && m_cc == TIMEOUT_CYCLES) m_to = 1;
        end
        e.done = m_done; e.to = m_to; e.result = 8'(m_res);
        e.sc = 16'(m_sc); e.cc = 16'(m_cc); e.cs = 8'(m_cs);
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("done",      32'(done),      32'(e.done));
                chk("timeout",   32'(timeout),   32'(e.to));
                chk("result",    32'(result),    32'(e.result));
                chk("store_cnt", 32'(store_cnt), 32'(e.sc));
                chk("cycle_cnt", 32'(cycle_cnt), 32'(e.cc));
                chk("log_addr",  32'(log_addr),  32'(e.la));
                chk("log_data",  32'(log_data),  32'(e.ld));
                chk("log_vld",   32'(log_vld),   32'(e.lv));
`ifdef STORE_MON_CHECKSUM_EN
                chk("csum",      32'(csum),      32'(e.cs));
`endif
            end
        end
    end

    initial begin
        // Directed: program ending with (255,42), then read back the log.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 10, 1, 0);
        step(0, 1, 11, 2, 0);
        step(0, 1, 255, 42, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, k % 4);
        step(0, 1, 255, 99, 0);

        // Wrap-around: 10 stores over an 8-deep log.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, i, 100 + i, i % 8);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, k);
        step(0, 0, 0, 0, 7);

        // Checksum pattern 0x01 then 0x80.
        step(1, 0, 0, 0, 0);
        step(0, 1, 3, 8'h01, 0);
        step(0, 1, 4, 8'h80, 0);
        step(0, 0, 0, 0, 1);

        // Timeout with no stores; later terminating store ignored.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT_CYCLES + 5; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 255, 9, 0);
        step(0, 0, 0, 0, 0);

        // Terminating store exactly on the timeout edge.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) step(0, 0, 0, 0, 0);
        step(0, 1, 255, 7, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Mid-run reset after 3 stores.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 11, 0);
        step(0, 1, 2, 22, 0);
        step(0, 1, 3, 33, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 255, 5, 0);
        step(0, 0, 0, 0, 0);

        // Randomized runs, including reads that collide with writes.
        for (int run = 0; run < 4; run++) begin
            int len;
            len = (run == 3) ? 1100 : int'($urandom_range(50, 400));
            step(1, 0, 0, 0, 0);
            for (int i = 0; i < len; i++) begin
                int a;
                if (run == 3) a = int'($urandom_range(0, 254));
                else a = ($urandom_range(0, 40) == 0) ? 255 : int'($urandom_range(0, 254));
                step(0, $urandom_range(0, 1) == 1, a, int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 7)));
            end
        end

        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
